// File: rtl/wire_arb_pkg.sv
// ============================================================================
// Module : wire_arb_pkg
// Brief  : Shared state encoding and sizing helper for the wire arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wire_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wire_rr_pick.sv
// ============================================================================
// Module : wire_rr_pick
// Brief  : Combinational round-robin picker; first set req at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wire_rr_pick
    import wire_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] sel,
    output logic [N-1:0]  onehot
);

    int            w_sum;
    logic [PW-1:0] w_idx;

    // Walk ptr, ptr+1 ... wrapping at N; the first hit wins.
    always_comb begin
        valid  = 1'b0;
        sel    = '0;
        onehot = '0;
        w_sum  = 0;
        w_idx  = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(ptr) + i;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = PW'(w_sum);
            if (!valid && req[w_idx]) begin
                valid         = 1'b1;
                sel           = w_idx;
                onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wire_arbiter.sv
// ============================================================================
// Module : wire_arbiter
// Brief  : Round-robin owner of one shared wire with hold limit and gap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wire_arbiter
    import wire_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int GAP      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] din,
    output logic [N-1:0] gnt,
    output logic         out,
    output logic         busy
);

    localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam int HW = clog2(MAX_HOLD + 1);
    localparam int GW = (GAP > 0) ? clog2(GAP + 1) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;
    logic [HW-1:0] r_hold;
    logic [GW-1:0] r_gap;
    logic [N-1:0]  r_gnt;
    logic          r_out;

    logic          w_valid;
    logic [PW-1:0] w_sel;
    logic [N-1:0]  w_onehot;
    logic          w_release;

    wire_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .sel    (w_sel),
        .onehot (w_onehot)
    );

    // Losing the request and hitting the hold limit together is one release.
    assign w_release = !req[r_idx] || (r_hold == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_hold  <= '0;
            r_gap   <= '0;
            r_gnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= w_onehot;
                        r_idx   <= w_sel;
                        r_out   <= din[w_sel];
                        r_hold  <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_out   <= 1'b0;
                        r_ptr   <= (r_idx == PTR_LAST) ? '0 : r_idx + 1'b1;
                        r_gap   <= '0;
                        r_state <= (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                        r_out  <= din[r_idx];
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign out  = r_out;
    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wire_arbiter.sv
// ============================================================================
// Module : tb_wire_arbiter
// Brief  : Scoreboard bench for wire_arbiter (N=4, MAX_HOLD=4, GAP=1 and GAP=0).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wire_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic       out;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, din, req0, din0;
    logic [3:0] gnt, gnt0;
    logic       out, busy, out0, busy0;

    exp_t  q1[$];
    exp_t  q0[$];
    exp_t  e1, e0;
    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    always #5 clk = ~clk;

    wire_arbiter #(.N(4), .MAX_HOLD(4), .GAP(1)) dut (
        .clk (clk), .rst (rst), .req (req), .din (din),
        .gnt (gnt), .out (out), .busy (busy)
    );

    wire_arbiter #(.N(4), .MAX_HOLD(4), .GAP(0)) dut0 (
        .clk (clk), .rst (rst), .req (req0), .din (din0),
        .gnt (gnt0), .out (out0), .busy (busy0)
    );

    // Scoreboard consumer: one expected entry per edge, popped just after it.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks++;
            if ({gnt, out, busy} !== {e1.gnt, e1.out, e1.busy}) begin
                errors++;
                $display("FAIL %s gap1 t=%0t gnt/out/busy got %b/%b/%b want %b/%b/%b",
                         tag, $time, gnt, out, busy, e1.gnt, e1.out, e1.busy);
            end
        end
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            if ({gnt0, out0, busy0} !== {e0.gnt, e0.out, e0.busy}) begin
                errors++;
                $display("FAIL %s gap0 t=%0t gnt/out/busy got %b/%b/%b want %b/%b/%b",
                         tag, $time, gnt0, out0, busy0, e0.gnt, e0.out, e0.busy);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] d,
                         input logic [3:0] eg, input logic eo, input logic eb);
        exp_t e;
        req = r; din = d;
        e.gnt = eg; e.out = eo; e.busy = eb;
        q1.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic drive0(input logic [3:0] r, input logic [3:0] d,
                          input logic [3:0] eg, input logic eo, input logic eb);
        exp_t e;
        req0 = r; din0 = d;
        e.gnt = eg; e.out = eo; e.busy = eb;
        q0.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tag = "reset";
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        checks++;
        if ({gnt, out, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid got %b/%b/%b want 0000/0/0", gnt, out, busy);
        end
        rst = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        tag = "single";
        drive(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1);
        drive(4'b0100, 4'b1011, 4'b0100, 1'b0, 1'b1);
        drive(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1);
        drive(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    // Each grant: 4 cycles, then one GAP cycle and one IDLE arbitration cycle.
    task automatic test_rotation();
        logic [3:0] d;
        int         g;
        tag = "rotation";
        do_reset();
        d = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            for (int c = 0; c < 4; c++) drive(4'b1111, d, 4'(1 << g), d[g], 1'b1);
            if (k < 4) begin
                drive(4'b1111, d, 4'b0000, 1'b0, 1'b1);
                drive(4'b1111, d, 4'b0000, 1'b0, 1'b0);
            end
        end
        drive(4'b0000, d, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, d, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_forced();
        logic [3:0] d;
        int         pos;
        tag = "forced";
        do_reset();
        for (int c = 0; c < 20; c++) begin
            d   = 4'($urandom_range(0, 15));
            pos = c % 6;
            if (pos < 4)       drive(4'b0010, d, 4'b0010, d[1], 1'b1);
            else if (pos == 4) drive(4'b0010, d, 4'b0000, 1'b0, 1'b1);
            else               drive(4'b0010, d, 4'b0000, 1'b0, 1'b0);
        end
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        tag = "async_reset";
        do_reset();
        drive(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1);
        drive(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL async_gnt got %b want 0000", gnt);
        end
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL async_out got %b want 0", out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL async_busy got %b want 0", busy);
        end
        #1;
        rst = 1'b0;
        drive(4'b1001, 4'b0001, 4'b0001, 1'b1, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    // Index 3 releases to ptr 0; req during GAP must be ignored.
    task automatic test_wrap();
        tag = "wrap";
        do_reset();
        drive(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b1001, 4'b1111, 4'b0001, 1'b1, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_gap0();
        tag = "gap0";
        req = 4'b0000;
        din = 4'b0000;
        do_reset();
        drive0(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1);
        drive0(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive0(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) drive0(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive0(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        drive0(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1);
        drive0(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        din  = 4'b0000;
        req0 = 4'b0000;
        din0 = 4'b0000;
        @(posedge clk); #2;
        test_reset();
        test_single();
        test_rotation();
        test_forced();
        test_async_reset();
        test_wrap();
        test_gap0();
        @(posedge clk); #2;
        checks++;
        if ((q1.size() + q0.size()) != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", q1.size() + q0.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
